// File: rtl/seg7_capture_if.sv
// Output handshake bundle for seg7_capture.
//   out_nibble : decoded 4-bit value (producer -> consumer)
//   out_valid  : out_nibble is valid, held until accepted
//   out_ready  : consumer accepts out_nibble this cycle
// master = producer (seg7_capture), slave = consumer.
interface seg7_capture_if;
  logic [3:0] out_nibble;
  logic       out_valid;
  logic       out_ready;

  modport master (output out_nibble, output out_valid, input out_ready);
  modport slave  (input out_nibble, input out_valid, output out_ready);
endinterface

// File: rtl/seg7_capture.sv
// Captures an active-low 7-segment pattern, waits for it to be stable for
// STABLE_CYCLES consecutive samples, decodes it to a hex nibble and stores
// it in one of four digit slots.
// Ports:
//   clk, rst_n   : rising-edge clock, synchronous active-low reset
//   seg          : active-low segments, seg[6]=a .. seg[0]=g
//   digit_sel    : target digit 0..3, latched with sample
//   sample       : one-cycle capture request (only honoured in IDLE)
//   busy         : high whenever the FSM is not in IDLE
//   out_if       : decoded nibble with valid/ready handshake
//   value        : digit n held in value[4n+3:4n]
//   digit_valid  : bit n set once digit n holds a decoded value
//   err          : one-cycle pulse on invalid pattern or settle timeout
//   err_code     : 01 invalid pattern, 10 timeout; held until next err
//   err_pattern  : pattern involved in the last error
module seg7_capture #(
  parameter int STABLE_CYCLES = 4,
  parameter int TIMEOUT       = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [6:0]        seg,
  input  logic [1:0]        digit_sel,
  input  logic              sample,
  output logic              busy,
  seg7_capture_if.master    out_if,
  output logic [15:0]       value,
  output logic [3:0]        digit_valid,
  output logic              err,
  output logic [1:0]        err_code,
  output logic [6:0]        err_pattern
);

  localparam int WW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, SETTLE, DECODE, HOLD} state_t;

  state_t         state_q;
  logic [6:0]     ref_q;
  logic [1:0]     sel_q;
  logic [7:0]     stab_q, stab_d;
  logic [WW-1:0]  wait_q, wait_d;
  logic [3:0]     nib_q;
  logic           valid_q;
  logic [15:0]    value_q;
  logic [3:0]     dvalid_q;
  logic           err_q;
  logic [1:0]     code_q;
  logic [6:0]     pat_q;
  logic [4:0]     dec;

  // Counters hold at all-ones instead of wrapping.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  function automatic logic [WW-1:0] sat_incw(input logic [WW-1:0] v);
    return (v == {WW{1'b1}}) ? v : v + {{(WW-1){1'b0}}, 1'b1};
  endfunction

  // Returns {hit, nibble}; hit=0 for any pattern outside the hex table.
  function automatic logic [4:0] decode7(input logic [6:0] s);
    case (s)
      7'b0000001: return {1'b1, 4'h0};
      7'b1001111: return {1'b1, 4'h1};
      7'b0010010: return {1'b1, 4'h2};
      7'b0000110: return {1'b1, 4'h3};
      7'b1001100: return {1'b1, 4'h4};
      7'b0100100: return {1'b1, 4'h5};
      7'b0100000: return {1'b1, 4'h6};
      7'b0001111: return {1'b1, 4'h7};
      7'b0000000: return {1'b1, 4'h8};
      7'b0001100: return {1'b1, 4'h9};
      7'b0001000: return {1'b1, 4'hA};
      7'b1100000: return {1'b1, 4'hB};
      7'b0110001: return {1'b1, 4'hC};
      7'b1000010: return {1'b1, 4'hD};
      7'b0110000: return {1'b1, 4'hE};
      7'b0111000: return {1'b1, 4'hF};
      default:    return 5'b0_0000;
    endcase
  endfunction

  always_comb begin
    stab_d = sat_inc8(stab_q);
    wait_d = sat_incw(wait_q);
    dec    = decode7(ref_q);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      ref_q    <= 7'h7F;
      sel_q    <= 2'd0;
      stab_q   <= 8'd0;
      wait_q   <= '0;
      nib_q    <= 4'd0;
      valid_q  <= 1'b0;
      value_q  <= 16'd0;
      dvalid_q <= 4'd0;
      err_q    <= 1'b0;
      code_q   <= 2'b00;
      pat_q    <= 7'h7F;
    end else begin
      err_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (sample) begin
            ref_q   <= seg;
            sel_q   <= digit_sel;
            stab_q  <= 8'd1;
            wait_q  <= {{(WW-1){1'b0}}, 1'b1};
            state_q <= SETTLE;
          end
        end
        SETTLE: begin
          wait_q <= wait_d;
          if (seg == ref_q) stab_q <= stab_d;
          else begin
            ref_q  <= seg;
            stab_q <= 8'd1;
          end
          // Reaching stability wins over a coincident timeout.
          if (seg == ref_q && stab_d == 8'(STABLE_CYCLES)) begin
            state_q <= DECODE;
          end else if (wait_d == WW'(TIMEOUT)) begin
            state_q <= IDLE;
            err_q   <= 1'b1;
            code_q  <= 2'b10;
            pat_q   <= ref_q;
          end
        end
        DECODE: begin
          if (dec[4]) begin
            value_q[{sel_q, 2'b00} +: 4] <= dec[3:0];
            dvalid_q[sel_q]              <= 1'b1;
            nib_q                        <= dec[3:0];
            valid_q                      <= 1'b1;
            state_q                      <= HOLD;
          end else begin
            err_q   <= 1'b1;
            code_q  <= 2'b01;
            pat_q   <= ref_q;
            state_q <= IDLE;
          end
        end
        HOLD: begin
          // seg and sample are ignored here; only the handshake leaves HOLD.
          if (out_if.out_ready) begin
            valid_q <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy              = (state_q != IDLE);
  assign out_if.out_nibble = nib_q;
  assign out_if.out_valid  = valid_q;
  assign value             = value_q;
  assign digit_valid       = dvalid_q;
  assign err               = err_q;
  assign err_code          = code_q;
  assign err_pattern       = pat_q;

endmodule

// File: tb/tb_seg7_capture.sv
module tb_seg7_capture;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [6:0]  seg;
  logic [1:0]  digit_sel;
  logic        sample;
  logic        busy;
  logic [15:0] value;
  logic [3:0]  digit_valid;
  logic        err;
  logic [1:0]  err_code;
  logic [6:0]  err_pattern;

  seg7_capture_if oif();

  seg7_capture #(.STABLE_CYCLES(4), .TIMEOUT(64)) dut (
    .clk(clk), .rst_n(rst_n), .seg(seg), .digit_sel(digit_sel),
    .sample(sample), .busy(busy), .out_if(oif), .value(value),
    .digit_valid(digit_valid), .err(err), .err_code(err_code),
    .err_pattern(err_pattern)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  logic [3:0]  sb[$];
  logic [6:0]  codes[16];
  logic [15:0] exp_value;
  logic [3:0]  exp_dv;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; the request is taken by the following posedge.
  task automatic do_sample(input logic [6:0] s, input logic [1:0] d);
    seg = s; digit_sel = d; sample = 1'b1;
    @(negedge clk);
    sample = 1'b0;
  endtask

  task automatic wait_valid(input string tag);
    bit ok = 1'b0;
    for (int k = 0; k < 50; k++) begin
      if (oif.out_valid === 1'b1) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    chk(tag, 32'(ok), 32'd1);
  endtask

  task automatic pop_check(input string tag);
    logic [3:0] e;
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      chk(tag, 32'(oif.out_nibble), 32'(e));
    end
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_value"}, 32'(value), 32'h0);
    chk({tag, "_dv"}, 32'(digit_valid), 32'h0);
    chk({tag, "_nib"}, 32'(oif.out_nibble), 32'h0);
    chk({tag, "_ovalid"}, 32'(oif.out_valid), 32'h0);
    chk({tag, "_err"}, 32'(err), 32'h0);
    chk({tag, "_ecode"}, 32'(err_code), 32'h0);
    chk({tag, "_epat"}, 32'(err_pattern), 32'h7F);
    chk({tag, "_busy"}, 32'(busy), 32'h0);
  endtask

  // Full capture with out_ready=1; ends at the negedge after the handshake.
  task automatic capture(input int n, input logic [1:0] d, input string tag);
    sb.push_back(4'(n));
    do_sample(codes[n], d);
    wait_valid({tag, "_valid"});
    pop_check({tag, "_nib"});
    exp_value[{d, 2'b00} +: 4] = 4'(n);
    exp_dv[d] = 1'b1;
    @(negedge clk);
    chk({tag, "_value"}, 32'(value), 32'(exp_value));
    chk({tag, "_dv"}, 32'(digit_valid), 32'(exp_dv));
    chk({tag, "_done"}, 32'({oif.out_valid, busy}), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    bit saw_valid;
    codes = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
              7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
              7'b0000000, 7'b0001100, 7'b0001000, 7'b1100000,
              7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};
    rst_n = 1'b0; seg = 7'h7F; digit_sel = 2'd0; sample = 1'b0;
    oif.out_ready = 1'b0;
    exp_value = 16'h0; exp_dv = 4'h0;
    @(negedge clk); @(negedge clk);
    check_reset("rst0");

    // Basic capture of '2' on digit 1, issued in the first cycle after release.
    rst_n = 1'b1; oif.out_ready = 1'b1;
    sb.push_back(4'h2);
    do_sample(7'b0010010, 2'd1);
    for (int i = 1; i <= 4; i++) begin
      chk($sformatf("lat_c%0d", i), 32'(oif.out_valid), 32'd0);
      @(negedge clk);
    end
    chk("lat_c5", 32'(oif.out_valid), 32'd1);
    pop_check("cap2_nib");
    chk("cap2_value", 32'(value), 32'h0020);
    chk("cap2_dv", 32'(digit_valid), 32'h2);
    exp_value = 16'h0020; exp_dv = 4'h2;
    @(negedge clk);
    chk("cap2_done", 32'({oif.out_valid, busy}), 32'd0);

    // Invalid pattern.
    do_sample(7'b1111110, 2'd0);
    cyc = 0;
    while (err !== 1'b1 && cyc < 20) begin @(negedge clk); cyc++; end
    chk("inv_err", 32'(err), 32'd1);
    chk("inv_code", 32'(err_code), 32'h1);
    chk("inv_pat", 32'(err_pattern), 32'h7E);
    chk("inv_value", 32'(value), 32'(exp_value));
    chk("inv_dv", 32'(digit_valid), 32'(exp_dv));
    @(negedge clk);
    chk("inv_pulse", 32'({err, busy, oif.out_valid}), 32'd0);
    chk("inv_code_hold", 32'(err_code), 32'h1);

    // Toggling input never settles -> timeout at wait_cnt=64.
    saw_valid = 1'b0;
    do_sample(7'b0000110, 2'd2);
    cyc = 1;
    while (err !== 1'b1 && cyc < 200) begin
      if (oif.out_valid === 1'b1) saw_valid = 1'b1;
      if (cyc % 2 == 0) seg = (seg == 7'b0000110) ? 7'b0000001 : 7'b0000110;
      @(negedge clk);
      cyc++;
    end
    chk("to_cycles", 32'(cyc), 32'd64);
    chk("to_code", 32'(err_code), 32'h2);
    chk("to_novalid", 32'(saw_valid), 32'd0);
    chk("to_pat", 32'(err_pattern == 7'b0000110 || err_pattern == 7'b0000001), 32'd1);
    chk("to_value", 32'(value), 32'(exp_value));
    seg = 7'h7F;
    @(negedge clk);

    // Back-pressure: F on digit 3, stalled 10 cycles with noise and a stray sample.
    oif.out_ready = 1'b0;
    sb.push_back(4'hF);
    do_sample(codes[15], 2'd3);
    wait_valid("bp_valid");
    for (int c = 0; c < 10; c++) begin
      chk($sformatf("bp_hold_v%0d", c), 32'(oif.out_valid), 32'd1);
      chk($sformatf("bp_hold_n%0d", c), 32'(oif.out_nibble), 32'hF);
      seg = codes[c];
      sample = (c == 3);
      digit_sel = 2'd0;
      @(negedge clk);
    end
    sample = 1'b0;
    pop_check("bp_nib");
    // Sample coincident with handshake completion must be dropped too.
    oif.out_ready = 1'b1; sample = 1'b1; seg = codes[0]; digit_sel = 2'd0;
    @(negedge clk);
    sample = 1'b0;
    exp_value[15:12] = 4'hF; exp_dv[3] = 1'b1;
    chk("bp_done", 32'({oif.out_valid, busy}), 32'd0);
    for (int c = 0; c < 8; c++) @(negedge clk);
    chk("bp_dropped_busy", 32'(busy), 32'd0);
    chk("bp_value", 32'(value), 32'(exp_value));
    chk("bp_dv", 32'(digit_valid), 32'(exp_dv));

    // Reset mid-SETTLE, then capture immediately after release.
    do_sample(codes[5], 2'd2);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check_reset("rst_settle");
    exp_value = 16'h0; exp_dv = 4'h0;
    rst_n = 1'b1;
    capture(5, 2'd2, "post_rst1");

    // Reset mid-HOLD with no handshake.
    oif.out_ready = 1'b0;
    do_sample(codes[9], 2'd0);
    wait_valid("hold_valid");
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check_reset("rst_hold");
    exp_value = 16'h0; exp_dv = 4'h0;
    rst_n = 1'b1; oif.out_ready = 1'b1;
    capture(7, 2'd1, "post_rst2");

    // Every code on every digit, back-to-back.
    for (int d = 0; d < 4; d++)
      for (int n = 0; n < 16; n++)
        capture(n, 2'(d), $sformatf("all_d%0d_n%0d", d, n));
    chk("all_dv", 32'(digit_valid), 32'hF);
    chk("all_value", 32'(value), 32'hFFFF);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
